// File: rtl/mem_interface.sv
// Memory access controller between the CPU datapath and a 512x32 RAM.
// Holds MAR/MDR, strobes ram_r/ram_w for WAIT_CYCLES cycles and pulses done.
module mem_interface #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_r,
    output logic              ram_w,
    input  logic [DATA_W-1:0] ram_dout
);

    // state | meaning
    // IDLE  | accepts MAR/MDR loads and a single read or write request
    // RD    | ram_r held high, counting down the wait window
    // WR    | ram_w held high, counting down the wait window
    // DONE  | done pulse cycle; loads honoured, requests rejected
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ram_r_q, ram_r_d;
    logic              ram_w_q, ram_w_d;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ram_r_d = ram_r_q;
        ram_w_d = ram_w_q;

        case (state_q)
            S_IDLE: begin
                if (mar_in) mar_d = bus_in[ADDR_W-1:0];
                if (mdr_in) mdr_d = bus_in;
                // the request latches the MAR value from before this edge
                if (read && write) begin
                    err_d = 1'b1;
                end else if (read || write) begin
                    addr_d  = mar_q;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    ram_r_d = read;
                    ram_w_d = write;
                    state_d = read ? S_RD : S_WR;
                end
            end
            S_RD, S_WR: begin
                if (read || write) err_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // capture on the last strobe cycle while ram_r is still high
                    if (state_q == S_RD) mdr_d = ram_dout;
                    ram_r_d = 1'b0;
                    ram_w_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (mar_in) mar_d = bus_in[ADDR_W-1:0];
                if (mdr_in) mdr_d = bus_in;
                if (read || write) err_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ram_r_q <= 1'b0;
            ram_w_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ram_r_q <= ram_r_d;
            ram_w_q <= ram_w_d;
        end
    end

    assign mdr_out  = mdr_q;
    assign ram_din  = mdr_q;
    assign ram_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ram_r    = ram_r_q;
    assign ram_w    = ram_w_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: WAIT_CYCLES=1 and =3 instances on shared inputs,
// each with its own combinational-read RAM.
module tb_mem_interface;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, mar_in, mdr_in, rd, wr, ram_init;
    logic [31:0] bus_in;

    logic [31:0] mdr1, din1, dout1, mdr3, din3, dout3;
    logic [8:0]  addr1, addr3;
    logic        busy1, done1, err1, r1, w1;
    logic        busy3, done3, err3, r3, w3;

    logic [31:0] mem1 [512];
    logic [31:0] mem3 [512];

    int checks = 0;
    int errors = 0;

    mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
        .clock(clock), .clear(clear), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .read(rd), .write(wr), .mdr_out(mdr1), .busy(busy1), .done(done1), .err(err1),
        .ram_addr(addr1), .ram_din(din1), .ram_r(r1), .ram_w(w1), .ram_dout(dout1));

    mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u3 (
        .clock(clock), .clear(clear), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .read(rd), .write(wr), .mdr_out(mdr3), .busy(busy3), .done(done3), .err(err3),
        .ram_addr(addr3), .ram_din(din3), .ram_r(r3), .ram_w(w3), .ram_dout(dout3));

    function automatic logic [31:0] init_val(int i);
        return 32'(i) * 32'd7 + 32'h0000_1000;
    endfunction

    assign dout1 = mem1[addr1];
    assign dout3 = mem3[addr3];

    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 512; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
        end else begin
            if (w1) mem1[addr1] <= din1;
            if (w3) mem3[addr3] <= din3;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("excl1", 32'(r1 & w1), 32'd0);
        chk("excl3", 32'(r3 & w3), 32'd0);
    endtask

    task automatic drive(input logic c, input logic mi, input logic di, input logic r,
                         input logic w, input logic [31:0] b);
        clear  = c;
        mar_in = mi;
        mdr_in = di;
        rd     = r;
        wr     = w;
        bus_in = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic expect1(input string nm, input logic eb, input logic ed, input logic ee,
                           input logic er, input logic ew, input logic [8:0] ea,
                           input logic [31:0] em);
        chk({nm, "_busy"}, 32'(busy1), 32'(eb));
        chk({nm, "_done"}, 32'(done1), 32'(ed));
        chk({nm, "_err"},  32'(err1),  32'(ee));
        chk({nm, "_r"},    32'(r1),    32'(er));
        chk({nm, "_w"},    32'(w1),    32'(ew));
        chk({nm, "_addr"}, 32'(addr1), 32'(ea));
        chk({nm, "_mdr"},  mdr1, em);
        chk({nm, "_din"},  din1, em);
    endtask

    task automatic expect3(input string nm, input logic eb, input logic ed, input logic ee,
                           input logic er, input logic ew, input logic [8:0] ea,
                           input logic [31:0] em);
        chk({nm, "_busy"}, 32'(busy3), 32'(eb));
        chk({nm, "_done"}, 32'(done3), 32'(ed));
        chk({nm, "_err"},  32'(err3),  32'(ee));
        chk({nm, "_r"},    32'(r3),    32'(er));
        chk({nm, "_w"},    32'(w3),    32'(ew));
        chk({nm, "_addr"}, 32'(addr3), 32'(ea));
        chk({nm, "_mdr"},  mdr3, em);
        chk({nm, "_din"},  din3, em);
    endtask

    typedef struct {
        logic        clr, mar, mdr, r, w;
        logic [31:0] bus;
        logic        e_busy, e_done, e_err, e_r, e_w;
        logic [8:0]  e_addr;
        logic [31:0] e_mdr;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic clr, input logic mar, input logic mdr,
                                input logic r, input logic w, input logic [31:0] bus,
                                input logic eb, input logic ed, input logic ee,
                                input logic er, input logic ew, input logic [8:0] ea,
                                input logic [31:0] em);
        vec_t v;
        v = '{clr, mar, mdr, r, w, bus, eb, ed, ee, er, ew, ea, em};
        vq.push_back(v);
    endfunction

    // reference model state for the randomized WAIT_CYCLES=3 run
    localparam int W = 3;
    bit          m_act;
    bit          m_wr;
    int          m_s;
    logic [8:0]  m_mar, m_addr, m_old_mar;
    logic [31:0] m_mdr;
    logic [31:0] m_mem [512];
    logic        c_i, mi_i, di_i, r_i, w_i;
    logic [31:0] b_i;
    logic        e_err, e_strobe, e_done, in_win, free;

    initial begin
        for (int i = 0; i < 512; i++) m_mem[i] = init_val(i);
        ram_init = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick();
        ram_init = 1'b0;
        expect3("rst3", 0, 0, 0, 0, 0, 9'd0, 32'd0);

        // clr mar mdr r w bus        | busy done err r w addr mdr
        add(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 9'd0,   32'd0);
        add(1, 0, 0, 0, 1, 32'h0000_1234, 0, 0, 0, 0, 0, 9'd0,   32'd0);
        add(0, 1, 0, 0, 0, 32'd100,       0, 0, 0, 0, 0, 9'd0,   32'd0);
        add(0, 0, 1, 0, 0, 32'd145,       0, 0, 0, 0, 0, 9'd0,   32'd145);
        add(0, 0, 0, 0, 1, 32'd0,         1, 0, 0, 0, 1, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 0, 0, 0, 0, 9'd100, 32'd145);
        add(0, 1, 0, 0, 0, 32'd200,       0, 0, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 1, 0, 0, 32'd245,       0, 0, 0, 0, 0, 9'd100, 32'd245);
        add(0, 0, 0, 0, 1, 32'd0,         1, 0, 0, 0, 1, 9'd200, 32'd245);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd200, 32'd245);
        add(0, 1, 0, 0, 0, 32'd300,       0, 0, 0, 0, 0, 9'd200, 32'd245);
        add(0, 0, 1, 0, 0, 32'd345,       0, 0, 0, 0, 0, 9'd200, 32'd345);
        add(0, 0, 0, 0, 1, 32'd0,         1, 0, 0, 0, 1, 9'd300, 32'd345);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd300, 32'd345);
        add(0, 1, 0, 0, 0, 32'd100,       0, 0, 0, 0, 0, 9'd300, 32'd345);
        add(0, 0, 0, 1, 0, 32'd0,         1, 0, 0, 1, 0, 9'd100, 32'd345);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd100, 32'd145);
        add(0, 1, 0, 0, 0, 32'd300,       0, 0, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 1, 0, 32'd0,         1, 0, 0, 1, 0, 9'd300, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd300, 32'd345);
        add(0, 0, 0, 0, 0, 32'd0,         0, 0, 0, 0, 0, 9'd300, 32'd345);
        add(0, 0, 0, 1, 1, 32'd0,         0, 0, 1, 0, 0, 9'd300, 32'd345);
        add(0, 1, 0, 0, 0, 32'd100,       0, 0, 0, 0, 0, 9'd300, 32'd345);
        add(0, 0, 0, 1, 0, 32'd0,         1, 0, 0, 1, 0, 9'd100, 32'd345);
        add(0, 1, 0, 0, 0, 32'd55,        0, 1, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 0, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 1, 0, 32'd0,         1, 0, 0, 1, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 1, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 0, 0, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 1, 32'd0,         1, 0, 0, 0, 1, 9'd100, 32'd145);
        add(0, 0, 1, 1, 0, 32'd999,       0, 1, 1, 0, 0, 9'd100, 32'd145);
        add(0, 0, 0, 0, 0, 32'd0,         0, 0, 0, 0, 0, 9'd100, 32'd145);

        foreach (vq[i]) begin
            drive(vq[i].clr, vq[i].mar, vq[i].mdr, vq[i].r, vq[i].w, vq[i].bus);
            tick();
            expect1($sformatf("v%0d", i), vq[i].e_busy, vq[i].e_done, vq[i].e_err,
                    vq[i].e_r, vq[i].e_w, vq[i].e_addr, vq[i].e_mdr);
        end

        // randomized run on the WAIT_CYCLES=3 instance against a timeline model
        m_act = 1'b0;
        m_wr  = 1'b0;
        m_s   = 0;
        m_mar = '0;
        m_addr = '0;
        m_mdr = '0;
        for (int n = 0; n < 500; n++) begin
            c_i  = (n == 0) || ($urandom_range(0, 63) == 0);
            mi_i = ($urandom_range(0, 2) == 0);
            di_i = ($urandom_range(0, 2) == 0);
            r_i  = ($urandom_range(0, 3) == 0);
            w_i  = ($urandom_range(0, 3) == 0);
            b_i  = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 7));
            drive(c_i, mi_i, di_i, r_i, w_i, b_i);
            tick();

            in_win = m_act && (n > m_s) && (n <= m_s + W);
            if (in_win && m_wr) m_mem[m_addr] = m_mdr;
            e_err = 1'b0;
            if (c_i) begin
                m_act  = 1'b0;
                m_mar  = '0;
                m_mdr  = '0;
                m_addr = '0;
            end else begin
                free = !m_act || (n >= m_s + W + 2);
                e_err = (r_i || w_i) && (!free || (r_i && w_i));
                m_old_mar = m_mar;
                if (!in_win) begin
                    if (mi_i) m_mar = b_i[8:0];
                    if (di_i) m_mdr = b_i;
                end
                if (m_act && n == m_s + W && !m_wr) m_mdr = m_mem[m_addr];
                if (free && (r_i ^ w_i)) begin
                    m_act  = 1'b1;
                    m_s    = n;
                    m_wr   = w_i;
                    m_addr = m_old_mar;
                end
            end
            e_strobe = m_act && (n >= m_s) && (n < m_s + W);
            e_done   = m_act && (n == m_s + W);
            expect3($sformatf("rnd%0d", n), e_strobe, e_done, e_err,
                    e_strobe && !m_wr, e_strobe && m_wr, m_addr, m_mdr);
        end

        // WAIT_CYCLES=3 hand sequences
        drive(1, 1, 0, 1, 0, 32'h5A5A_5A5A);
        tick();
        expect3("h_rst", 0, 0, 0, 0, 0, 9'd0, 32'd0);
        drive(0, 1, 0, 0, 0, 32'd200); tick();
        drive(0, 0, 1, 0, 0, 32'd245); tick();
        drive(0, 0, 0, 0, 1, 32'd0);   tick();
        expect3("w200_e0", 1, 0, 0, 0, 1, 9'd200, 32'd245);
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect3($sformatf("w200_k%0d", k), k < 3, k == 3, 0, 0, k < 3, 9'd200, 32'd245);
        end
        drive(0, 1, 0, 0, 0, 32'd100); tick();
        drive(0, 0, 1, 0, 0, 32'd145); tick();
        drive(0, 0, 0, 0, 1, 32'd0);   tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect3($sformatf("w100_k%0d", k), k < 3, k == 3, 0, 0, k < 3, 9'd100, 32'd145);
        end
        drive(0, 0, 1, 0, 0, 32'h0000_DEAD); tick();
        expect3("lat_pre", 0, 0, 0, 0, 0, 9'd100, 32'h0000_DEAD);
        drive(0, 0, 0, 1, 0, 32'd0); tick();
        expect3("lat_e0", 1, 0, 0, 1, 0, 9'd100, 32'h0000_DEAD);
        drive(0, 1, 0, 0, 0, 32'd55); tick();
        expect3("lat_k1_mar55", 1, 0, 0, 1, 0, 9'd100, 32'h0000_DEAD);
        idle(); tick();
        expect3("lat_k2", 1, 0, 0, 1, 0, 9'd100, 32'h0000_DEAD);
        tick();
        expect3("lat_k3", 0, 1, 0, 0, 0, 9'd100, 32'd145);
        drive(0, 0, 0, 1, 0, 32'd0); tick();
        expect3("lat_k4_rej", 0, 0, 1, 0, 0, 9'd100, 32'd145);
        tick();
        expect3("lat_k5_acc", 1, 0, 0, 1, 0, 9'd100, 32'd145);
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect3($sformatf("lat2_k%0d", k), k < 3, k == 3, 0, k < 3, 0, 9'd100, 32'd145);
        end

        drive(0, 1, 0, 0, 0, 32'd200); tick();
        drive(0, 0, 0, 1, 0, 32'd0);   tick();
        expect3("abort_e0", 1, 0, 0, 1, 0, 9'd200, 32'd145);
        idle(); tick();
        expect3("abort_k1", 1, 0, 0, 1, 0, 9'd200, 32'd145);
        drive(1, 0, 0, 0, 0, 32'd0); tick();
        expect3("abort_clr", 0, 0, 0, 0, 0, 9'd0, 32'd0);
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect3($sformatf("abort_after%0d", k), 0, 0, 0, 0, 0, 9'd0, 32'd0);
        end
        drive(0, 1, 0, 0, 0, 32'd200); tick();
        drive(0, 0, 0, 1, 0, 32'd0);   tick();
        expect3("re200_e0", 1, 0, 0, 1, 0, 9'd200, 32'd0);
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect3($sformatf("re200_k%0d", k), k < 3, k == 3, 0, k < 3, 0, 9'd200,
                    (k >= 3) ? 32'd245 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
